// File: rtl/complex_div.sv
// Sequential complex divider z = a / b computed as a*conj(b) / |b|^2.
// Real and imag quotients share one restoring-divider control loop, one bit per cycle.
module complex_div #(
  parameter int unsigned AWIDTH   = 16,
  parameter int unsigned BWIDTH   = 16,
  parameter int unsigned FRAC     = 14,
  parameter int unsigned OUTWIDTH = 24
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [AWIDTH-1:0]   a_real,
  input  logic [AWIDTH-1:0]   a_imag,
  input  logic [BWIDTH-1:0]   b_real,
  input  logic [BWIDTH-1:0]   b_imag,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [OUTWIDTH-1:0] z_real,
  output logic [OUTWIDTH-1:0] z_imag,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                div_zero,
  output logic                sat
);

  localparam int unsigned PW   = AWIDTH + BWIDTH;
  localparam int unsigned NW   = PW + 1;
  localparam int unsigned DENW = 2 * BWIDTH;
  localparam int unsigned DW   = AWIDTH + BWIDTH + FRAC;
  localparam int unsigned RW   = DENW + 1;
  localparam int unsigned CW   = $clog2(DW);

  localparam logic [DW-1:0] POS_LIM = {{(DW-OUTWIDTH+1){1'b0}}, {(OUTWIDTH-1){1'b1}}};
  localparam logic [DW-1:0] NEG_LIM = POS_LIM + DW'(1);

  typedef enum logic [2:0] {IDLE, MUL1, MUL2, DIV, DONE} state_t;

  state_t                      state_q, state_d;
  logic signed [AWIDTH-1:0]    a_re_q, a_re_d, a_im_q, a_im_d;
  logic signed [BWIDTH-1:0]    b_re_q, b_re_d, b_im_q, b_im_d;
  logic signed [PW-1:0]        p_rr_q, p_rr_d, p_ii_q, p_ii_d, p_ir_q, p_ir_d, p_ri_q, p_ri_d;
  logic [DENW-1:0]             b_rr_q, b_rr_d, b_ii_q, b_ii_d;
  logic [DENW-1:0]             den_q, den_d;
  logic                        neg_re_q, neg_re_d, neg_im_q, neg_im_d;
  logic [DW-1:0]               dvd_re_q, dvd_re_d, dvd_im_q, dvd_im_d;
  logic [RW-1:0]               rem_re_q, rem_re_d, rem_im_q, rem_im_d;
  logic [CW-1:0]               cnt_q, cnt_d;
  logic                        in_ready_q, in_ready_d, out_valid_q, out_valid_d;
  logic                        div_zero_q, div_zero_d, sat_q, sat_d;
  logic [OUTWIDTH-1:0]         z_re_q, z_re_d, z_im_q, z_im_d;

  logic signed [NW-1:0]        num_re_c, num_im_c;
  logic [PW-1:0]               mag_re_c, mag_im_c;
  logic [RW+DW-1:0]            step_re_c, step_im_c;
  logic [OUTWIDTH:0]           fin_re_c, fin_im_c;

  // One restoring step: shift in the next dividend bit, subtract if it fits, shift in the quotient bit.
  function automatic logic [RW+DW-1:0] div_step(input logic [RW-1:0] rem,
                                                input logic [DW-1:0] dvd,
                                                input logic [DENW-1:0] den);
    logic [RW-1:0] trial;
    trial = {rem[RW-2:0], dvd[DW-1]};
    if (trial >= RW'(den)) div_step = {trial - RW'(den), dvd[DW-2:0], 1'b1};
    else                   div_step = {trial, dvd[DW-2:0], 1'b0};
  endfunction

  // Apply sign to the truncated magnitude and clamp; returns {sat, z}.
  function automatic logic [OUTWIDTH:0] finish(input logic neg, input logic [DW-1:0] q);
    if (neg) begin
      if (q > NEG_LIM) finish = {1'b1, 1'b1, {(OUTWIDTH-1){1'b0}}};
      else             finish = {1'b0, OUTWIDTH'(-q)};
    end else begin
      if (q > POS_LIM) finish = {1'b1, 1'b0, {(OUTWIDTH-1){1'b1}}};
      else             finish = {1'b0, OUTWIDTH'(q)};
    end
  endfunction

  assign num_re_c  = NW'(p_rr_q) + NW'(p_ii_q);
  assign num_im_c  = NW'(p_ir_q) - NW'(p_ri_q);
  // |num| never exceeds 2^(PW-1), so the magnitude fits in PW unsigned bits.
  assign mag_re_c  = num_re_c[NW-1] ? PW'(-num_re_c) : PW'(num_re_c);
  assign mag_im_c  = num_im_c[NW-1] ? PW'(-num_im_c) : PW'(num_im_c);
  assign step_re_c = div_step(rem_re_q, dvd_re_q, den_q);
  assign step_im_c = div_step(rem_im_q, dvd_im_q, den_q);
  assign fin_re_c  = finish(neg_re_q, dvd_re_q);
  assign fin_im_c  = finish(neg_im_q, dvd_im_q);

  // Next-state and datapath
  always_comb begin
    state_d     = state_q;
    a_re_d      = a_re_q;   a_im_d = a_im_q;
    b_re_d      = b_re_q;   b_im_d = b_im_q;
    p_rr_d      = p_rr_q;   p_ii_d = p_ii_q;
    p_ir_d      = p_ir_q;   p_ri_d = p_ri_q;
    b_rr_d      = b_rr_q;   b_ii_d = b_ii_q;
    den_d       = den_q;
    neg_re_d    = neg_re_q; neg_im_d = neg_im_q;
    dvd_re_d    = dvd_re_q; dvd_im_d = dvd_im_q;
    rem_re_d    = rem_re_q; rem_im_d = rem_im_q;
    cnt_d       = cnt_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    div_zero_d  = div_zero_q;
    sat_d       = sat_q;
    z_re_d      = z_re_q;   z_im_d = z_im_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_re_d     = a_real; a_im_d = a_imag;
          b_re_d     = b_real; b_im_d = b_imag;
          in_ready_d = 1'b0;
          state_d    = MUL1;
        end
      end
      MUL1: begin
        p_rr_d  = PW'(a_re_q) * PW'(b_re_q);
        p_ii_d  = PW'(a_im_q) * PW'(b_im_q);
        p_ir_d  = PW'(a_im_q) * PW'(b_re_q);
        p_ri_d  = PW'(a_re_q) * PW'(b_im_q);
        b_rr_d  = DENW'(b_re_q) * DENW'(b_re_q);
        b_ii_d  = DENW'(b_im_q) * DENW'(b_im_q);
        state_d = MUL2;
      end
      MUL2: begin
        den_d    = b_rr_q + b_ii_q;
        neg_re_d = num_re_c[NW-1];
        neg_im_d = num_im_c[NW-1];
        dvd_re_d = DW'(mag_re_c) << FRAC;
        dvd_im_d = DW'(mag_im_c) << FRAC;
        rem_re_d = '0;
        rem_im_d = '0;
        cnt_d    = CW'(DW - 1);
        state_d  = DIV;
      end
      DIV: begin
        {rem_re_d, dvd_re_d} = step_re_c;
        {rem_im_d, dvd_im_d} = step_im_c;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) state_d = DONE;
      end
      DONE: begin
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
          if (den_q == '0) begin
            z_re_d = '0; z_im_d = '0; sat_d = 1'b0; div_zero_d = 1'b1;
          end else begin
            z_re_d     = fin_re_c[OUTWIDTH-1:0];
            z_im_d     = fin_im_c[OUTWIDTH-1:0];
            sat_d      = fin_re_c[OUTWIDTH] | fin_im_c[OUTWIDTH];
            div_zero_d = 1'b0;
          end
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      a_re_q      <= '0; a_im_q <= '0; b_re_q <= '0; b_im_q <= '0;
      p_rr_q      <= '0; p_ii_q <= '0; p_ir_q <= '0; p_ri_q <= '0;
      b_rr_q      <= '0; b_ii_q <= '0; den_q  <= '0;
      neg_re_q    <= 1'b0; neg_im_q <= 1'b0;
      dvd_re_q    <= '0; dvd_im_q <= '0; rem_re_q <= '0; rem_im_q <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      div_zero_q  <= 1'b0;
      sat_q       <= 1'b0;
      z_re_q      <= '0; z_im_q <= '0;
    end else begin
      state_q     <= state_d;
      a_re_q      <= a_re_d; a_im_q <= a_im_d; b_re_q <= b_re_d; b_im_q <= b_im_d;
      p_rr_q      <= p_rr_d; p_ii_q <= p_ii_d; p_ir_q <= p_ir_d; p_ri_q <= p_ri_d;
      b_rr_q      <= b_rr_d; b_ii_q <= b_ii_d; den_q  <= den_d;
      neg_re_q    <= neg_re_d; neg_im_q <= neg_im_d;
      dvd_re_q    <= dvd_re_d; dvd_im_q <= dvd_im_d; rem_re_q <= rem_re_d; rem_im_q <= rem_im_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      div_zero_q  <= div_zero_d;
      sat_q       <= sat_d;
      z_re_q      <= z_re_d; z_im_q <= z_im_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign z_real    = z_re_q;
  assign z_imag    = z_im_q;
  assign div_zero  = div_zero_q;
  assign sat       = sat_q;

endmodule

// File: tb/tb_complex_div.sv
// Randomized self-checking bench for complex_div against an integer-arithmetic reference model.
module tb_complex_div;

  localparam int LATENCY = 49;

  logic               clk = 1'b0;
  logic               rst;
  logic signed [15:0] a_real, a_imag, b_real, b_imag;
  logic               in_valid, in_ready;
  logic signed [23:0] z_real, z_imag;
  logic               out_valid, out_ready, div_zero, sat;

  int n_checks = 0;
  int n_fail   = 0;

  complex_div dut (
    .clk(clk), .rst(rst),
    .a_real(a_real), .a_imag(a_imag), .b_real(b_real), .b_imag(b_imag),
    .in_valid(in_valid), .in_ready(in_ready),
    .z_real(z_real), .z_imag(z_imag),
    .out_valid(out_valid), .out_ready(out_ready),
    .div_zero(div_zero), .sat(sat)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: z = trunc(a*conj(b)/|b|^2 * 2^14), clamped to 24-bit signed.
  task automatic model(input longint ar, ai, br, bi,
                       output longint zr, zi, output logic dz, st);
    longint nr, ni, den, q, lim_p, lim_n;
    lim_p = 8388607; lim_n = -8388608;
    nr  = ar * br + ai * bi;
    ni  = ai * br - ar * bi;
    den = br * br + bi * bi;
    dz = 1'b0; st = 1'b0;
    if (den == 0) begin
      zr = 0; zi = 0; dz = 1'b1;
    end else begin
      q  = ((nr < 0 ? -nr : nr) * 16384) / den;
      zr = (nr < 0) ? -q : q;
      q  = ((ni < 0 ? -ni : ni) * 16384) / den;
      zi = (ni < 0) ? -q : q;
      if (zr > lim_p) begin zr = lim_p; st = 1'b1; end
      if (zr < lim_n) begin zr = lim_n; st = 1'b1; end
      if (zi > lim_p) begin zi = lim_p; st = 1'b1; end
      if (zi < lim_n) begin zi = lim_n; st = 1'b1; end
    end
  endtask

  function automatic logic signed [15:0] rnd_op();
    case ($urandom_range(0, 5))
      0:       rnd_op = -16'sd32768;
      1:       rnd_op = 16'sd32767;
      2:       rnd_op = 16'sd0;
      3:       rnd_op = 16'($signed($urandom_range(0, 8)) - 4);
      default: rnd_op = 16'($urandom);
    endcase
  endfunction

  // Issue one operation, check latency/result, optionally stall the output for `stall` cycles.
  task automatic do_op(input logic signed [15:0] ar, ai, br, bi, input int stall);
    longint ezr, ezi;
    logic   edz, est;
    int     lat, waited;
    logic signed [23:0] hr, hi;
    model(ar, ai, br, bi, ezr, ezi, edz, est);
    waited = 0;
    while (!in_ready && waited < 10) begin tick(); waited++; end
    check("in_ready_before", in_ready, 1);
    a_real = ar; a_imag = ai; b_real = br; b_imag = bi;
    in_valid  = 1'b1;
    out_ready = (stall == 0);
    tick();
    in_valid = 1'b0;
    a_real = 16'($urandom); a_imag = 16'($urandom);
    b_real = 16'($urandom); b_imag = 16'($urandom);
    check("in_ready_busy", in_ready, 0);
    lat = 0;
    while (!out_valid && lat < 200) begin tick(); lat++; end
    check("latency", lat, LATENCY);
    check("z_real", z_real, ezr);
    check("z_imag", z_imag, ezi);
    check("div_zero", div_zero, edz);
    check("sat", sat, est);
    if (stall > 0) begin
      hr = z_real; hi = z_imag;
      in_valid = 1'b1;
      for (int i = 0; i < stall; i++) begin
        tick();
        check("stall_valid", out_valid, 1);
        check("stall_in_ready", in_ready, 0);
        check("stall_z_real", z_real, hr);
        check("stall_z_imag", z_imag, hi);
      end
      out_ready = 1'b1;
    end
    tick();
    in_valid = 1'b0;
    check("post_valid", out_valid, 0);
    check("post_in_ready", in_ready, 1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a_real = '0; a_imag = '0; b_real = '0; b_imag = '0;
    tick(); tick();
    rst = 1'b0;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_z_real", z_real, 0);
    check("rst_z_imag", z_imag, 0);
    check("rst_div_zero", div_zero, 0);
    check("rst_sat", sat, 0);

    do_op(16'sd100, 16'sd0, 16'sd100, 16'sd0, 0);
    do_op(16'sd3, 16'sd4, 16'sd1, -16'sd2, 0);
    do_op(16'sd1, 16'sd0, 16'sd3, 16'sd0, 0);
    do_op(-16'sd1, 16'sd0, 16'sd3, 16'sd0, 0);
    do_op(16'sd32767, 16'sd0, 16'sd1, 16'sd0, 0);
    do_op(-16'sd32768, 16'sd0, 16'sd1, 16'sd0, 0);
    do_op(16'sd5, 16'sd5, 16'sd0, 16'sd0, 0);
    do_op(-16'sd32768, -16'sd32768, -16'sd32768, -16'sd32768, 0);
    do_op(16'sd1234, -16'sd77, 16'sd300, 16'sd45, 10);

    // Reset in the middle of DIV aborts the operation.
    a_real = 16'sd7; a_imag = 16'sd9; b_real = 16'sd2; b_imag = 16'sd1;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (20) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_in_ready", in_ready, 1);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_z_real", z_real, 0);
    check("midrst_z_imag", z_imag, 0);
    do_op(16'sd100, 16'sd0, 16'sd100, 16'sd0, 0);

    for (int n = 0; n < 40; n++)
      do_op(rnd_op(), rnd_op(), rnd_op(), rnd_op(), ($urandom_range(0, 7) == 0) ? 3 : 0);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
